// File: rtl/skid_register.sv
// skid_register: elastic pipeline stage with a one-entry skid buffer.
// Cuts the combinational ready path: in_ready depends only on local state,
// never on out_ready, while still sustaining one transfer per cycle.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous reset, active-high (valids cleared, data <= DEF)
//   flush     - synchronous clear of buffered entries (data registers hold)
//   in_valid  - upstream presents in_data
//   in_ready  - stage can accept a beat
//   in_data   - upstream payload, W bits
//   out_valid - main entry holds valid data
//   out_ready - downstream accepts the main entry
//   out_data  - main entry payload, W bits
//   count     - number of entries held (0, 1 or 2)
module skid_register #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  DEF = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  // Encoding chosen so bit 0 is main_valid and bit 1 is skid_valid; the
  // handshake outputs then come straight off the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;

  logic         acc_c;
  logic         take_c;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = main_q;
  assign count     = 2'(state_q[0]) + 2'(state_q[1]);

  assign acc_c  = in_valid & in_ready;
  assign take_c = out_valid & out_ready;

  // State and data registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= DEF;
      skid_q  <= DEF;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and data-load decisions.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any beat accepted this cycle is dropped; payload registers hold.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_c) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc_c && take_c) begin
            main_d  = in_data;
          end else if (acc_c) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (take_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take_c) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: doc/skid_register.md
# skid_register

Parametrised pipeline register with a valid/ready handshake, a one-entry skid buffer, a programmable reset value and a synchronous flush. It generalises the plain enable register into an elastic stage. It sustains one transfer per cycle and keeps in_ready free of any combinational dependence on out_ready. It sits between datapath stages wherever backpressure must be cut for timing.

## Interface
- W, 8: data width in bits.
- DEF, 0 (W bits): value loaded into both data registers at reset.

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of buffered entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
- in_data  input  W  upstream payload.
- out_valid  output  1  main entry holds valid data.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
- out_data  output  W  main entry payload.
- count  output  2  entries held: 0, 1 or 2.

## Operation
- Storage is two registers, main (main_data, main_valid) and skid (skid_data, skid_valid).
- out_valid = main_valid and out_data = main_data, both direct from flops.
- in_ready = ~skid_valid, a direct flop output with no path from out_ready.
- count = main_valid + skid_valid.
- States are EMPTY (0/0), ONE (1/0) and FULL (1/1). The skid entry is never valid while main is empty.
- Let acc = in_valid & in_ready and take = out_valid & out_ready.
- EMPTY:
  - acc: main <= in_data, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - acc & take: main <= in_data, stay in ONE.
  - acc & ~take: skid <= in_data, go to FULL.
  - ~acc & take: go to EMPTY.
  - Otherwise hold.
- FULL (in_ready = 0):
  - take: main <= skid_data, go to ONE.
  - Otherwise hold.
- Data order is strictly FIFO. No entry is duplicated or dropped except by flush or rst.
- Priority is rst > flush > normal operation.
- rst:
  - main_valid and skid_valid are cleared.
  - main_data and skid_data are loaded with DEF.
- flush:
  - main_valid and skid_valid are cleared. Data registers hold their values.
  - Upstream may still see a completed handshake that cycle, since in_ready reflects pre-flush state. That beat is discarded.
  - A downstream take in the flush cycle counts as delivered.
- Data registers load only on the transitions listed above. A register whose valid is 0 is don't-care for payload, but holds its value deterministically.

## Timing
- Reset values: out_valid=0, out_data=DEF, in_ready=1, count=0.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Backpressure:
  - If out_ready drops while the stage is in ONE, one extra beat is absorbed into skid.
  - in_ready falls on the next edge.
- Recovery: in FULL, in_ready returns high the cycle after the first take.
- rst or flush mid-transfer: takes effect at that edge. The first new accept occurs at the following edge at the earliest.
- Upstream must hold in_valid/in_data stable until accepted. The stage does not check this.

## Test plan
- Reset: with W=8, DEF=8'hA5, assert rst for 2 cycles -> out_valid=0, out_data=8'hA5, in_ready=1, count=0.
- Streaming: out_ready=1, send 8'h01..8'h10 back-to-back -> the same sequence appears on out_data one cycle later, with no bubbles, in_ready constantly 1 and count ≤ 1.
- Skid:
  - Send 8'h11, then 8'h22 while out_ready drops in the cycle 8'h22 is accepted -> count=2, in_ready=0, out_data=8'h11.
  - Raise out_ready -> 8'h11, then 8'h22 delivered in consecutive cycles, and in_ready returns to 1 one cycle after 8'h11's take.
- Stall hold: fill to FULL with 8'h33/8'h44, hold out_ready=0 for 10 cycles -> out_data stays 8'h33, count=2, no change.
- Flush in FULL with simultaneous in_valid=1 (in_data=8'h55) -> next cycle count=0, out_valid=0. 8'h55 never appears on out_data.
- Reset vs flush priority: assert rst and flush together from FULL -> out_data=DEF, count=0. Then random valid/ready traffic for 1000 cycles -> a scoreboard shows in-order delivery with no loss.
